unidade_controle_asteroide: RTL
===============================

Name: unidade_controle_asteroide

Overview:
- Moore FSM that sequences the asteroid-movement and lives-decrement datapath (fluxo_dados) once per movement tick.
- Per tick it computes and stores the new X coordinate, then the new Y coordinate, then checks for a collision or hit.
- On a collision it decrements lives and respawns the asteroid; on a hit it only respawns it.
- Sits between the top-level game module and fluxo_dados; its outputs connect one-to-one to the datapath's control inputs.

Parameters:
- TICK_CYCLES, 50000, clock cycles spent in ESPERA per movement tick; legal range 1..65535.
- CNT_W, 16, width of the tick counter; must satisfy 2^CNT_W > TICK_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- iniciar  in  1  start/restart request; sampled only in INICIAL and FIM.
- dir_x  in  1  X direction: 0 = add, 1 = subtract.
- dir_y  in  1  Y direction: 0 = add, 1 = subtract.
- rapido  in  1  increment select (0 = step 1, 1 = large step); drives select_mux_incremento.
- colisao  in  1  from datapath: asteroid overlaps ship.
- acertou  in  1  from datapath: shot hit asteroid.
- vidas  in  1  from datapath: 1 while at least one life remains.
- clear_reg_asteroide  out  1  clears the asteroid X and Y registers.
- enable_reg_asteroide_x  out  1  loads the adder result into the X register.
- enable_reg_asteroide_y  out  1  loads the adder result into the Y register.
- select_mux_coor  out  1  0 = X operand, 1 = Y operand.
- select_mux_incremento  out  1  increment select.
- select_sum_sub  out  1  0 = sum, 1 = subtract.
- clear_decrementer  out  1  clears the lives decrementer.
- load_decrementer  out  1  loads the initial lives count.
- ent_decrementer  out  1  decrements lives by 1.
- fim_jogo  out  1  high in FIM.
- jogando  out  1  high in every state except INICIAL and FIM.
- db_estado  out  4  current state encoding, for debug.

Behaviour:
- Reset is synchronous and active-low. With reset low at a rising edge:
  - state goes to INICIAL, the tick counter clears, and the latched dir_x/dir_y/rapido clear;
  - all outputs are 0 and db_estado is 0.
- Reset asserted mid-tick aborts the tick immediately. No register-enable pulse may appear in the cycle after reset.
- All outputs decode from the current state and latched registers only; no output depends combinationally on inputs.
- State encodings and transitions:
  - INICIAL (0): all outputs 0. If iniciar = 1 -> PREPARA; otherwise stay.
  - PREPARA (1): clear_reg_asteroide = 1 and load_decrementer = 1. Unconditionally -> ESPERA. Counter = 0.
  - ESPERA (2): counter increments each cycle. On the cycle where counter = TICK_CYCLES-1: latch dir_x, dir_y and rapido, clear the counter, -> CALC_X.
  - CALC_X (3): select_mux_coor = 0, select_sum_sub = latched dir_x. -> GRAVA_X.
  - GRAVA_X (4): same selects as CALC_X, plus enable_reg_asteroide_x = 1. -> CALC_Y.
  - CALC_Y (5): select_mux_coor = 1, select_sum_sub = latched dir_y. -> GRAVA_Y.
  - GRAVA_Y (6): same selects as CALC_Y, plus enable_reg_asteroide_y = 1. -> VERIFICA.
  - VERIFICA (7): no outputs asserted. colisao = 1 -> COLIDIU; else acertou = 1 -> ACERTOU; else -> ESPERA.
  - COLIDIU (8): ent_decrementer = 1 and clear_reg_asteroide = 1. -> CHECA_VIDAS.
  - CHECA_VIDAS (9): waits one cycle for the decrement to settle. vidas = 0 -> FIM; else -> ESPERA.
  - ACERTOU (10): clear_reg_asteroide = 1. -> ESPERA.
  - FIM (11): fim_jogo = 1. If iniciar = 1 -> PREPARA, which reloads lives; otherwise stay.
- select_mux_incremento = latched rapido in states 3-6, and 0 elsewhere.
- Each enable and ent_decrementer is exactly a one-cycle pulse per tick.
- Tick period is TICK_CYCLES + 5 cycles with no event, TICK_CYCLES + 7 with a collision, and TICK_CYCLES + 6 with a hit.
- Simultaneous colisao and acertou in VERIFICA: colisao wins, and exactly one decrement occurs.
- colisao and acertou are ignored outside VERIFICA. iniciar is ignored outside INICIAL and FIM.
- Direction changes during ESPERA take effect only at the latch point.
- With TICK_CYCLES = 1, ESPERA lasts exactly one cycle.
- Unused encodings 12-15 -> INICIAL on the next clock.

Decomposition:
- Shared package (asteroides_pkg): state encodings (localparams E_INICIAL..E_FIM) and the select constants COOR_X/COOR_Y and OP_SOMA/OP_SUB.
- One sub-module, contador_tick: CNT_W-bit counter with synchronous clear and enable, and a terminal-count flag at TICK_CYCLES-1.
- The FSM is the top of the block.

Test Plan (TICK_CYCLES = 4):
- Reset and start: hold reset low 2 cycles -> all outputs 0, db_estado = 0. Then iniciar = 1 for 1 cycle -> PREPARA for one cycle with clear_reg_asteroide = load_decrementer = 1, then db_estado = 2.
- Normal tick, dir_x = 0, dir_y = 1, rapido = 1:
  - after 4 ESPERA cycles, enable_x pulses with sel_coor = 0, sum_sub = 0, incr = 1;
  - two cycles later enable_y pulses with sel_coor = 1, sum_sub = 1;
  - back to ESPERA; tick period is 9 cycles.
- Collision with vidas = 1: colisao = 1 during VERIFICA -> one cycle of ent_decrementer = 1 with clear_reg_asteroide = 1, then CHECA_VIDAS, then ESPERA.
- Last life, then restart: vidas = 0 in CHECA_VIDAS -> FIM with fim_jogo = 1 held for 10 cycles. Then iniciar = 1 -> PREPARA with load_decrementer = 1.
- Simultaneous events: colisao = acertou = 1 in VERIFICA -> COLIDIU, exactly one ent_decrementer pulse, no ACERTOU visit. acertou alone -> ACERTOU with clear only, ent_decrementer stays 0.
- Mid-operation reset: reset low during GRAVA_X -> next cycle db_estado = 0 and all outputs 0. After release, no enable pulse until iniciar is asserted.

Source files
------------

// File: rtl/asteroides_pkg.sv
// rtl/asteroides_pkg.sv - state encodings and datapath select constants for the asteroid control unit
package asteroides_pkg;

    localparam logic [3:0] E_INICIAL     = 4'd0;
    localparam logic [3:0] E_PREPARA     = 4'd1;
    localparam logic [3:0] E_ESPERA      = 4'd2;
    localparam logic [3:0] E_CALC_X      = 4'd3;
    localparam logic [3:0] E_GRAVA_X     = 4'd4;
    localparam logic [3:0] E_CALC_Y      = 4'd5;
    localparam logic [3:0] E_GRAVA_Y     = 4'd6;
    localparam logic [3:0] E_VERIFICA    = 4'd7;
    localparam logic [3:0] E_COLIDIU     = 4'd8;
    localparam logic [3:0] E_CHECA_VIDAS = 4'd9;
    localparam logic [3:0] E_ACERTOU     = 4'd10;
    localparam logic [3:0] E_FIM         = 4'd11;

    localparam logic COOR_X  = 1'b0;
    localparam logic COOR_Y  = 1'b1;
    localparam logic OP_SOMA = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    typedef enum logic [3:0] {
        INICIAL     = E_INICIAL,
        PREPARA     = E_PREPARA,
        ESPERA      = E_ESPERA,
        CALC_X      = E_CALC_X,
        GRAVA_X     = E_GRAVA_X,
        CALC_Y      = E_CALC_Y,
        GRAVA_Y     = E_GRAVA_Y,
        VERIFICA    = E_VERIFICA,
        COLIDIU     = E_COLIDIU,
        CHECA_VIDAS = E_CHECA_VIDAS,
        ACERTOU     = E_ACERTOU,
        FIM         = E_FIM
    } estado_t;

endpackage

// File: rtl/unidade_controle_asteroide_if.sv
// rtl/unidade_controle_asteroide_if.sv - control/status link between the asteroid FSM and fluxo_dados
interface unidade_controle_asteroide_if;
    logic clear_reg_asteroide;
    logic enable_reg_asteroide_x;
    logic enable_reg_asteroide_y;
    logic select_mux_coor;
    logic select_mux_incremento;
    logic select_sum_sub;
    logic clear_decrementer;
    logic load_decrementer;
    logic ent_decrementer;
    logic colisao;
    logic acertou;
    logic vidas;

    modport master (
        output clear_reg_asteroide, enable_reg_asteroide_x, enable_reg_asteroide_y,
               select_mux_coor, select_mux_incremento, select_sum_sub,
               clear_decrementer, load_decrementer, ent_decrementer,
        input  colisao, acertou, vidas
    );

    modport slave (
        input  clear_reg_asteroide, enable_reg_asteroide_x, enable_reg_asteroide_y,
               select_mux_coor, select_mux_incremento, select_sum_sub,
               clear_decrementer, load_decrementer, ent_decrementer,
        output colisao, acertou, vidas
    );
endinterface

// File: rtl/unidade_controle_asteroide_contador_tick.sv
// rtl/unidade_controle_asteroide_contador_tick.sv - movement tick counter with terminal flag at TICK_CYCLES-1
module contador_tick #(
    parameter int TICK_CYCLES = 50000,
    parameter int CNT_W       = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign terminal = (count == CNT_W'(TICK_CYCLES - 1));
endmodule

// File: rtl/unidade_controle_asteroide.sv
// rtl/unidade_controle_asteroide.sv - Moore FSM sequencing asteroid movement, collision and lives per tick
module unidade_controle_asteroide
    import asteroides_pkg::*;
#(
    parameter int TICK_CYCLES = 50000,
    parameter int CNT_W       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        dir_x,
    input  logic        dir_y,
    input  logic        rapido,
    output logic        fim_jogo,
    output logic        jogando,
    output logic [3:0]  db_estado,
    unidade_controle_asteroide_if.master dp
);
    estado_t estado, proximo;
    logic    dir_x_q, dir_y_q, rapido_q;
    logic    tick_fim, trava;

    // Directions are frozen at the end of ESPERA so mid-wait changes cannot skew a tick.
    assign trava = (estado == ESPERA) && tick_fim;

    contador_tick #(.TICK_CYCLES(TICK_CYCLES), .CNT_W(CNT_W)) u_contador (
        .clock    (clock),
        .reset    (reset),
        .clear    ((estado != ESPERA) || tick_fim),
        .enable   (estado == ESPERA),
        .terminal (tick_fim)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado   <= INICIAL;
            dir_x_q  <= 1'b0;
            dir_y_q  <= 1'b0;
            rapido_q <= 1'b0;
        end else begin
            estado <= proximo;
            if (trava) begin
                dir_x_q  <= dir_x;
                dir_y_q  <= dir_y;
                rapido_q <= rapido;
            end
        end
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:     proximo = iniciar ? PREPARA : INICIAL;
            PREPARA:     proximo = ESPERA;
            ESPERA:      proximo = tick_fim ? CALC_X : ESPERA;
            CALC_X:      proximo = GRAVA_X;
            GRAVA_X:     proximo = CALC_Y;
            CALC_Y:      proximo = GRAVA_Y;
            GRAVA_Y:     proximo = VERIFICA;
            VERIFICA:    proximo = dp.colisao ? COLIDIU : (dp.acertou ? ACERTOU : ESPERA);
            COLIDIU:     proximo = CHECA_VIDAS;
            CHECA_VIDAS: proximo = dp.vidas ? ESPERA : FIM;
            ACERTOU:     proximo = ESPERA;
            FIM:         proximo = iniciar ? PREPARA : FIM;
            default:     proximo = INICIAL;
        endcase
    end

    always_comb begin
        dp.clear_reg_asteroide    = 1'b0;
        dp.enable_reg_asteroide_x = 1'b0;
        dp.enable_reg_asteroide_y = 1'b0;
        dp.select_mux_coor        = COOR_X;
        dp.select_mux_incremento  = 1'b0;
        dp.select_sum_sub         = OP_SOMA;
        dp.clear_decrementer      = 1'b0;
        dp.load_decrementer       = 1'b0;
        dp.ent_decrementer        = 1'b0;
        fim_jogo                  = 1'b0;
        jogando                   = 1'b1;
        case (estado)
            INICIAL: jogando = 1'b0;
            PREPARA: begin
                dp.clear_reg_asteroide = 1'b1;
                dp.load_decrementer    = 1'b1;
            end
            CALC_X, GRAVA_X: begin
                dp.select_mux_coor        = COOR_X;
                dp.select_sum_sub         = dir_x_q;
                dp.select_mux_incremento  = rapido_q;
                dp.enable_reg_asteroide_x = (estado == GRAVA_X);
            end
            CALC_Y, GRAVA_Y: begin
                dp.select_mux_coor        = COOR_Y;
                dp.select_sum_sub         = dir_y_q;
                dp.select_mux_incremento  = rapido_q;
                dp.enable_reg_asteroide_y = (estado == GRAVA_Y);
            end
            COLIDIU: begin
                dp.ent_decrementer     = 1'b1;
                dp.clear_reg_asteroide = 1'b1;
            end
            ACERTOU: dp.clear_reg_asteroide = 1'b1;
            FIM: begin
                fim_jogo = 1'b1;
                jogando  = 1'b0;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;
endmodule
